// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the oversampled receiver and the tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // Clocks per oversample tick; never below 1 so a tick can always occur.
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Host-side receive interface of the oversampled UART receiver.
// rx_valid is a one-cycle strobe with no ready: the receiver cannot stall, so the
// host must take rx_data and the status flags in the cycle rx_valid is high
// (they also hold until the next strobe). busy and state are live status.
interface uart_rx_os_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  break_det;
  logic                  busy;
  rx_state_e             state;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, busy, state
  );

  modport slave (
    input rx_data, rx_valid, parity_err, frame_err, break_det, busy, state
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks while en is high.
// Holding en low parks the counter at 0 so the tick phase follows the enable edge.
module uart_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 2-FF synchroniser, 3-sample majority per bit,
// optional parity, 1 or 2 stop bits, and parity/framing/break status per character.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_os_if.master rx_if
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] S_MID_LO = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam parity_e       PAR = parity_e'(2'(PARITY_MODE));

  logic                  sync1;
  logic                  rx_s;
  rx_state_e             state;
  logic [SW-1:0]         s_cnt;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic                  v_lo;
  logic                  v_mid;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  par_bit;
  logic                  ferr_p;
  logic                  lockout;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  parity_err_q;
  logic                  frame_err_q;
  logic                  break_q;

  logic tick;
  logic maj;
  logic at_dec;
  logic at_end;
  logic par_exp;
  logic ferr_next;
  logic brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  uart_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .tick (tick)
  );

  // The third vote is the live synchronised input at the decision sample.
  assign maj       = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);
  assign at_dec    = tick && (s_cnt == S_DEC);
  assign at_end    = tick && (s_cnt == S_END);
  assign par_exp   = (^data_sh) ^ (PAR == PAR_ODD);
  assign ferr_next = ferr_p | ~maj;
  assign brk       = ~(|data_sh) && ((PAR == PAR_NONE) || !par_bit) && ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      v_lo         <= 1'b0;
      v_mid        <= 1'b0;
      data_sh      <= '0;
      par_bit      <= 1'b0;
      ferr_p       <= 1'b0;
      lockout      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (tick) begin
        s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + 1'b1;
        if (s_cnt == S_MID_LO) v_lo  <= rx_s;
        if (s_cnt == S_MID)    v_mid <= rx_s;
      end
      case (state)
        IDLE: begin
          s_cnt    <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (rx_s) begin
            lockout <= 1'b0;
          end else if (!lockout) begin
            state  <= START;
            ferr_p <= 1'b0;
          end
        end
        START: begin
          if (at_dec && maj) begin
            state <= IDLE;
          end else if (at_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (at_dec) data_sh <= {maj, data_sh[DATA_WIDTH-1:1]};
          if (at_end) begin
            if (bit_idx == B_LAST) begin
              state <= (PAR != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_dec) par_bit <= maj;
          if (at_end) state <= STOP;
        end
        STOP: begin
          // Leave at the final decision, mid stop bit, so a following start edge is seen.
          if (at_dec) begin
            ferr_p <= ferr_next;
            if (stop_idx == STOP_LAST) begin
              state        <= DONE;
              rx_valid_q   <= 1'b1;
              rx_data_q    <= data_sh;
              parity_err_q <= (PAR != PAR_NONE) && (par_bit != par_exp);
              frame_err_q  <= ferr_next;
              break_q      <= brk;
              lockout      <= brk;
            end
          end else if (at_end) begin
            stop_idx <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.break_det  = break_q;
  assign rx_if.busy       = (state != IDLE);
  assign rx_if.state      = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int BITC     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_p  = 1'b1;
  logic rx_b  = 1'b1;

  always #5 clk = ~clk;

  uart_rx_os_if #(.DATA_WIDTH(8)) if_a ();
  uart_rx_os_if #(.DATA_WIDTH(8)) if_p ();
  uart_rx_os_if #(.DATA_WIDTH(8)) if_b ();

  uart_rx_os #(.DATA_WIDTH(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
               .PARITY_MODE(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_if(if_a));
  uart_rx_os #(.DATA_WIDTH(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
               .PARITY_MODE(1), .STOP_BITS(1))
    dut_p (.clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_if(if_p));
  uart_rx_os #(.DATA_WIDTH(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
               .PARITY_MODE(0), .STOP_BITS(2))
    dut_b (.clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_if(if_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vcnt_a = 0;
  int vcnt_p = 0;
  int vcnt_b = 0;
  int vcyc_a = 0;
  always @(negedge clk) if (if_a.rx_valid) begin vcnt_a++; vcyc_a = cyc; end
  always @(negedge clk) if (if_p.rx_valid) vcnt_p++;
  always @(negedge clk) if (if_b.rx_valid) vcnt_b++;

  int tests = 0;
  int fails = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int u, input logic v);
    case (u)
      0: rx_a = v;
      1: rx_p = v;
      default: rx_b = v;
    endcase
  endtask

  task automatic drive_bit(input int u, input logic v);
    set_rx(u, v);
    repeat (BITC) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BITC) @(negedge clk);
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input bit use_par, input logic par,
                            input int nstop, input logic last_stop);
    start_cyc = cyc;
    drive_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
    if (use_par) drive_bit(u, par);
    for (int k = 0; k < nstop; k++) drive_bit(u, (k == nstop - 1) ? last_stop : 1'b1);
    set_rx(u, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int lat;
    logic [7:0] d7;
    logic       pexp;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(if_a.rx_data), 32'h0);
    check("rst_rx_valid", 32'(if_a.rx_valid), 32'h0);
    check("rst_flags", {29'h0, if_a.parity_err, if_a.frame_err, if_a.break_det}, 32'h0);
    check("rst_busy", 32'(if_a.busy), 32'h0);
    check("rst_state", 32'(if_a.state), 32'(IDLE));
    rst_n = 1'b1;
    idle_bits(2);

    // 8N1 0xA5 with latency from start-edge drive
    n0 = vcnt_a;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    lat = vcyc_a - start_cyc;
    idle_bits(1);
    check("a5_count", 32'(vcnt_a), 32'(n0 + 1));
    check("a5_data", 32'(if_a.rx_data), 32'hA5);
    check("a5_flags", {29'h0, if_a.parity_err, if_a.frame_err, if_a.break_det}, 32'h0);
    check("a5_latency", 32'(lat), 32'd157);

    // Start glitch: 4 clocks low
    n0 = vcnt_a;
    set_rx(0, 1'b0);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    check("glitch_busy_hi", 32'(if_a.busy), 32'h1);
    repeat (10) @(negedge clk);
    check("glitch_busy_lo", 32'(if_a.busy), 32'h0);
    idle_bits(2);
    check("glitch_count", 32'(vcnt_a), 32'(n0));

    // Even parity, 0x07 has three ones so the correct parity bit is 1
    d7 = 8'h07;
    pexp = ^d7;
    n0 = vcnt_p;
    send_frame(1, d7, 1'b1, 1'b1, 1, 1'b1);
    idle_bits(1);
    check("par1_data", 32'(if_p.rx_data), 32'h07);
    check("par1_err", 32'(if_p.parity_err), 32'(1'b1 != pexp));
    send_frame(1, d7, 1'b1, 1'b0, 1, 1'b1);
    idle_bits(1);
    check("par0_data", 32'(if_p.rx_data), 32'h07);
    check("par0_err", 32'(if_p.parity_err), 32'(1'b0 != pexp));
    check("par_ferr", 32'(if_p.frame_err), 32'h0);
    check("par_count", 32'(vcnt_p), 32'(n0 + 2));

    // Two stop bits, second one bad, then two clean back-to-back frames
    n0 = vcnt_b;
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 1'b0);
    check("stop_bad_count", 32'(vcnt_b), 32'(n0 + 1));
    check("stop_bad_ferr", 32'(if_b.frame_err), 32'h1);
    check("stop_bad_data", 32'(if_b.rx_data), 32'h3C);
    idle_bits(1);
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 1'b1);
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 1'b1);
    idle_bits(1);
    check("b2b_count", 32'(vcnt_b), 32'(n0 + 3));
    check("b2b_ferr", 32'(if_b.frame_err), 32'h0);
    check("b2b_data", 32'(if_b.rx_data), 32'h3C);

    // Break: 40 bit times low gives one zero frame, then lockout until rx high
    n0 = vcnt_a;
    set_rx(0, 1'b0);
    repeat (40 * BITC) @(negedge clk);
    check("brk_count", 32'(vcnt_a), 32'(n0 + 1));
    check("brk_data", 32'(if_a.rx_data), 32'h00);
    check("brk_det", 32'(if_a.break_det), 32'h1);
    check("brk_ferr", 32'(if_a.frame_err), 32'h1);
    set_rx(0, 1'b1);
    idle_bits(2);
    check("brk_no_repeat", 32'(vcnt_a), 32'(n0 + 1));
    send_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    check("post_brk_data", 32'(if_a.rx_data), 32'h55);
    check("post_brk_flags", {30'h0, if_a.frame_err, if_a.break_det}, 32'h0);
    check("post_brk_count", 32'(vcnt_a), 32'(n0 + 2));

    // Reset mid-DATA of 0xFF
    n0 = vcnt_a;
    set_rx(0, 1'b0);
    repeat (BITC) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (4 * BITC + 5) @(negedge clk);
    check("pre_rst_busy", 32'(if_a.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(if_a.rx_data), 32'h0);
    check("mid_rst_busy", 32'(if_a.busy), 32'h0);
    check("mid_rst_state", 32'(if_a.state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(6);
    check("mid_rst_no_valid", 32'(vcnt_a), 32'(n0));
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    check("post_rst_data", 32'(if_a.rx_data), 32'h81);
    check("post_rst_flags", {29'h0, if_a.parity_err, if_a.frame_err, if_a.break_det}, 32'h0);
    check("post_rst_count", 32'(vcnt_a), 32'(n0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
